hazard_forward_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS datapath. It keeps a shadow scoreboard of destination registers in flight in the EX, MEM and WB stages. From that scoreboard it drives the ALU operand forwarding selects, load-use and branch stalls (PC/IF-ID freeze plus ID/EX bubble), and the taken-branch IF/ID flush. It also keeps saturating stall and flush event counters for bring-up debug.

---
 rtl/hazard_forward_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Tracks in-flight destinations in EX/MEM/WB and derives forwarding, stalls, flushes and debug counters.
module hazard_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_branch,
  input  logic             regs_equal,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             stall_needed,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [2:0]       forward_a,
  output logic [2:0]       forward_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [REG_W-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic             ex_wr, ex_ld, mem_wr, mem_ld, wb_wr;
  logic             ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic             load_use, branch_ex, branch_mem;
  logic             stall, take_branch;

  always_comb begin
    ex_hit_rs  = ex_wr  && (ex_dest  == id_rs) && (id_rs != '0);
    ex_hit_rt  = ex_wr  && (ex_dest  == id_rt) && (id_rt != '0);
    mem_hit_rs = mem_wr && (mem_dest == id_rs) && (id_rs != '0);
    mem_hit_rt = mem_wr && (mem_dest == id_rt) && (id_rt != '0);
    load_use   = ex_ld && ((id_uses_rs && ex_hit_rs) || (id_uses_rt && ex_hit_rt));
    branch_ex  = id_branch && (ex_hit_rs || ex_hit_rt);
    branch_mem = id_branch && mem_ld && (mem_hit_rs || mem_hit_rt);
    // Gating with rst lets an in-flight stall or redirect drop the moment reset rises.
    stall       = !rst && (load_use || branch_ex || branch_mem);
    take_branch = !rst && id_branch && regs_equal && !stall;
  end

  always_comb begin
    forward_a = 3'd0;
    if (mem_wr && (mem_dest == ex_rs) && (ex_rs != '0))
      forward_a = 3'd2;
    else if (wb_wr && (wb_dest == ex_rs) && (ex_rs != '0))
      forward_a = 3'd1;
  end

  always_comb begin
    forward_b = 3'd0;
    if (mem_wr && (mem_dest == ex_rt) && (ex_rt != '0))
      forward_b = 3'd2;
    else if (wb_wr && (wb_dest == ex_rt) && (ex_rt != '0))
      forward_b = 3'd1;
  end

  assign pc_write     = !stall;
  assign ifid_write   = !stall;
  assign stall_needed = stall;
  assign ifid_flush   = take_branch;
  assign pc_src       = take_branch;

  // Shadow of the datapath pipeline registers; a stall injects an all-zero bubble into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dest  <= '0;
      ex_wr    <= 1'b0;
      ex_ld    <= 1'b0;
      mem_dest <= '0;
      mem_wr   <= 1'b0;
      mem_ld   <= 1'b0;
      wb_dest  <= '0;
      wb_wr    <= 1'b0;
    end else begin
      wb_dest  <= mem_dest;
      wb_wr    <= mem_wr;
      mem_dest <= ex_dest;
      mem_wr   <= ex_wr;
      mem_ld   <= ex_ld;
      if (stall) begin
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_dest <= '0;
        ex_wr   <= 1'b0;
        ex_ld   <= 1'b0;
      end else begin
        ex_rs   <= id_uses_rs ? id_rs : '0;
        ex_rt   <= id_uses_rt ? id_rt : '0;
        ex_dest <= id_dest;
        ex_wr   <= id_reg_write;
        ex_ld   <= id_mem_read;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (take_branch && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl; expected outputs queue up as each ID instruction is driven.
// A second 8-bit-counter instance shares the stimulus so stall-counter saturation is reachable quickly.
module tb_hazard_forward_ctrl;

  typedef struct {
    string      tag;
    logic       stall;
    logic       flush;
    logic [2:0] fa;
    logic [2:0] fb;
    int         sc;
    int         fc;
    int         sc8;
    int         fc8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_branch, regs_equal;
  logic        pc_write, ifid_write, stall_needed, ifid_flush, pc_src;
  logic [2:0]  forward_a, forward_b;
  logic [15:0] stall_count, flush_count;
  logic        pc_write8, ifid_write8, stall_needed8, ifid_flush8, pc_src8;
  logic [2:0]  forward_a8, forward_b8;
  logic [7:0]  stall_count8, flush_count8;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   m_sc = 0, m_fc = 0, m_sc8 = 0, m_fc8 = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_branch(id_branch), .regs_equal(regs_equal),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_needed(stall_needed),
    .ifid_flush(ifid_flush), .pc_src(pc_src),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_forward_ctrl #(.REG_W(5), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_branch(id_branch), .regs_equal(regs_equal),
    .pc_write(pc_write8), .ifid_write(ifid_write8), .stall_needed(stall_needed8),
    .ifid_flush(ifid_flush8), .pc_src(pc_src8),
    .forward_a(forward_a8), .forward_b(forward_b8),
    .stall_count(stall_count8), .flush_count(flush_count8)
  );

  function automatic int satInc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic chk(input string tag, input string sig, input logic [15:0] got, input logic [15:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("[TB] FAIL %s.%s observed %0h expected %0h", tag, sig, got, want);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                       input logic [4:0] dest, input logic rw, input logic mr,
                       input logic br, input logic eq);
    id_rs = rs; id_rt = rt; id_uses_rs = ur; id_uses_rt = ut;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr;
    id_branch = br; regs_equal = eq;
  endtask

  task automatic applyStimulus(input string tag,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                               input logic [4:0] dest, input logic rw, input logic mr,
                               input logic br, input logic eq,
                               input logic st, input logic fl, input logic [2:0] fa, input logic [2:0] fb);
    exp_t x;
    drive(rs, rt, ur, ut, dest, rw, mr, br, eq);
    x.tag = tag; x.stall = st; x.flush = fl; x.fa = fa; x.fb = fb;
    x.sc = m_sc; x.fc = m_fc; x.sc8 = m_sc8; x.fc8 = m_fc8;
    sb.push_back(x);
  endtask

  task automatic checkOutput(output exp_t x);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL scoreboard observed empty expected entry");
      x.tag = "none"; x.stall = 1'b0; x.flush = 1'b0; x.fa = '0; x.fb = '0;
      x.sc = 0; x.fc = 0; x.sc8 = 0; x.fc8 = 0;
    end else begin
      x = sb.pop_front();
      chk(x.tag, "pc_write",     pc_write,     !x.stall);
      chk(x.tag, "ifid_write",   ifid_write,   !x.stall);
      chk(x.tag, "stall_needed", stall_needed, x.stall);
      chk(x.tag, "ifid_flush",   ifid_flush,   x.flush);
      chk(x.tag, "pc_src",       pc_src,       x.flush);
      chk(x.tag, "forward_a",    forward_a,    x.fa);
      chk(x.tag, "forward_b",    forward_b,    x.fb);
      chk(x.tag, "stall_count",  stall_count,  x.sc[15:0]);
      chk(x.tag, "flush_count",  flush_count,  x.fc[15:0]);
      chk(x.tag, "ctl8",
          {5'b0, pc_write8, ifid_write8, stall_needed8, ifid_flush8, pc_src8, forward_a8, forward_b8},
          {5'b0, !x.stall, !x.stall, x.stall, x.flush, x.flush, x.fa, x.fb});
      chk(x.tag, "cnt8", {stall_count8, flush_count8}, {x.sc8[7:0], x.fc8[7:0]});
    end
  endtask

  // Check at the falling edge, then account for what the coming rising edge will count.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    checkOutput(x);
    if (!rst) begin
      if (x.stall) begin
        m_sc  = satInc(m_sc, 65535);
        m_sc8 = satInc(m_sc8, 255);
      end
      if (x.flush) begin
        m_fc  = satInc(m_fc, 65535);
        m_fc8 = satInc(m_fc8, 255);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runStep(input string tag,
                         input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                         input logic [4:0] dest, input logic rw, input logic mr,
                         input logic br, input logic eq,
                         input logic st, input logic fl, input logic [2:0] fa, input logic [2:0] fb);
    applyStimulus(tag, rs, rt, ur, ut, dest, rw, mr, br, eq, st, fl, fa, fb);
    tick();
  endtask

  initial begin
    //         tag          rs rt ur ut ds rw mr br eq   st fl fa fb
    applyStimulus("reset",   0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tick();
    rst = 1'b0;

    runStep("s1_add3",       1, 2, 1, 1, 3, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("s2_sub5",       3, 3, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("s3_exmem",      0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 2);
    runStep("s4_wr0",        1, 0, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("s5_rd0",        0, 0, 1, 1, 7, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("s6_zero",       0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    runStep("s7_nop",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    runStep("s8_nop",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    runStep("b1_add3",       1, 2, 1, 1, 3, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("b2_add3",       4, 5, 1, 1, 3, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("b3_or6",        3, 0, 1, 1, 6, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("b4_memprio",    0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0);
    runStep("b5_add3",       1, 2, 1, 1, 3, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("b6_nop",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    runStep("b7_or6",        3, 0, 1, 1, 6, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("b8_wbfwd",      0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);

    runStep("c1_lw2",        1, 0, 1, 0, 2, 1, 1, 0, 0,   0, 0, 0, 0);
    runStep("c2_lduse",      2, 1, 1, 1, 4, 1, 0, 0, 0,   1, 0, 0, 0);
    runStep("c3_retry",      2, 1, 1, 1, 4, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("c4_wbfwd",      0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);

    runStep("d1_lw2",        1, 0, 1, 0, 2, 1, 1, 0, 0,   0, 0, 0, 0);
    runStep("d2_beq_st1",    2, 2, 1, 1, 0, 0, 0, 1, 1,   1, 0, 0, 0);
    runStep("d3_beq_st2",    2, 2, 1, 1, 0, 0, 0, 1, 1,   1, 0, 0, 0);
    runStep("d4_beq_take",   2, 2, 1, 1, 0, 0, 0, 1, 1,   0, 1, 0, 0);
    runStep("d5_flushed",    0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    runStep("e1_add8",       1, 1, 1, 1, 8, 1, 0, 0, 0,   0, 0, 0, 0);
    runStep("e2_beq_alu",    8, 9, 1, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);
    runStep("e3_beq_go",     8, 9, 1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    runStep("e4_wbfwd",      0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);

    // Reset raised between edges while a load-use stall is active.
    runStep("f1_lw2",        1, 0, 1, 0, 2, 1, 1, 0, 0,   0, 0, 0, 0);
    applyStimulus("f2_stall",2, 1, 1, 1, 4, 1, 0, 0, 0,   1, 0, 0, 0);
    @(negedge clk);
    checkOutput(e);
    #1;
    rst = 1'b1;
    m_sc = 0; m_fc = 0; m_sc8 = 0; m_fc8 = 0;
    applyStimulus("f2_rst",  2, 1, 1, 1, 4, 1, 0, 0, 0,   0, 0, 0, 0);
    #1;
    checkOutput(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runStep("f3_after",      2, 1, 1, 1, 4, 1, 0, 0, 0,   0, 0, 0, 0);

    // Unhazarded taken branch every cycle drives the 16-bit flush counter into saturation.
    drive(0, 0, 1, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      m_fc  = satInc(m_fc, 65535);
      m_fc8 = satInc(m_fc8, 255);
    end
    #1;
    runStep("flush_sat",     0, 0, 1, 1, 0, 0, 0, 1, 1,   0, 1, 0, 0);
    runStep("flush_hold",    0, 0, 1, 1, 0, 0, 0, 1, 1,   0, 1, 0, 0);
    chk("flush_sat", "flush_count_max", flush_count, 16'hFFFF);

    runStep("g_nop1",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    runStep("g_nop2",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    runStep("g_nop3",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    for (int k = 0; k < 130; k++) begin
      runStep("g_lw",        0, 0, 1, 0, 2, 1, 1, 0, 0,   0, 0, 0, 0);
      runStep("g_beq1",      2, 0, 1, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);
      runStep("g_beq2",      2, 0, 1, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);
    end
    runStep("g_end",         0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    chk("stall_sat", "stall_count8_max", {8'h00, stall_count8}, 16'h00FF);
    chk("stall_sat", "stall_count16",    stall_count,           16'd260);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
